// File: rtl/serial_subtractor.sv
// serial_subtractor: computes diff = a - b - bin over WIDTH bits, DIGIT bits per
// clock, with the borrow carried between cycles in a register. A start/done
// handshake brackets each operation; results are held until the next completion.
// Optional status flags (ovf, neg) are compiled in when SERIAL_SUB_FLAGS_EN is defined.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
`ifdef SERIAL_SUB_FLAGS_EN
    ,
    output logic             ovf,
    output logic             neg
`endif
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    // DONE is a single non-busy cycle after the last digit; the done pulse and
    // result registers are written on the edge that leaves it, which lets a new
    // request be accepted on that same edge (one op every N+1 cycles).
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             borrow_q, borrow_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             zero_q, zero_d;
`ifdef SERIAL_SUB_FLAGS_EN
    logic             ovf_q, ovf_d;
    logic             neg_q, neg_d;
`endif

    int               base;
    logic [DIGIT-1:0] a_sl;
    logic [DIGIT-1:0] b_sl;
    logic [DIGIT:0]   slice;

    // Current digit: subtract with one extra bit so the MSB is the borrow out.
    always_comb begin
        base  = int'(cnt_q) * DIGIT;
        a_sl  = a_q[base +: DIGIT];
        b_sl  = b_q[base +: DIGIT];
        slice = {1'b0, a_sl} - {1'b0, b_sl} - (DIGIT + 1)'(borrow_q);
    end

    // Next-state, datapath update and result capture.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        done_d   = 1'b0;
        diff_d   = diff_q;
        bout_d   = bout_q;
        zero_d   = zero_q;
`ifdef SERIAL_SUB_FLAGS_EN
        ovf_d    = ovf_q;
        neg_d    = neg_q;
`endif
        case (state_q)
            S_IDLE: begin
                state_d = S_IDLE;
            end
            S_RUN: begin
                res_d[base +: DIGIT] = slice[DIGIT-1:0];
                borrow_d             = slice[DIGIT];
                if (cnt_q == CW'(N - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                // res_q and borrow_q are final here; publish them all at once.
                done_d  = 1'b1;
                diff_d  = res_q;
                bout_d  = borrow_q;
                zero_d  = (res_q == '0);
`ifdef SERIAL_SUB_FLAGS_EN
                ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_q[WIDTH-1] != a_q[WIDTH-1]);
                neg_d   = res_q[WIDTH-1];
`endif
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Requests are only honoured when not busy; operands latch here so the
        // input buses are free to change during the run.
        if (start && (state_q != S_RUN)) begin
            a_d      = a;
            b_d      = b;
            borrow_d = bin;
            cnt_d    = '0;
            state_d  = S_RUN;
        end
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            zero_q   <= 1'b1;
`ifdef SERIAL_SUB_FLAGS_EN
            ovf_q    <= 1'b0;
            neg_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            done_q   <= done_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            zero_q   <= zero_d;
`ifdef SERIAL_SUB_FLAGS_EN
            ovf_q    <= ovf_d;
            neg_q    <= neg_d;
`endif
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
    assign zero = zero_q;
`ifdef SERIAL_SUB_FLAGS_EN
    assign ovf  = ovf_q;
    assign neg  = neg_q;
`endif

endmodule
